// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS memory-access front end.
// State and exception-cause encodings plus the default handler vector.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE        = 2'd0,
        MIS_FETCH   = 2'd1,
        MIS_DATA    = 2'd2,
        BUS_TIMEOUT = 2'd3
    } cause_t;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0080;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding memory access.
// Expired is high during the last cycle the access may still complete.
module mem_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mips_mem_port.sv
// Variable-latency memory port for the multicycle MIPS datapath.
// Owns PC/EPC/IR/MDR and sequences fetches and loads/stores.
module mips_mem_port
    import mips_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_DEF),
    parameter int TIMEOUT = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Fetch_req,
    input  logic              Data_req,
    input  logic              Data_we,
    input  logic [ADDR_W-1:0] Alu_addr,
    input  logic [DATA_W-1:0] Store_data,
    input  logic              Pc_load,
    input  logic [ADDR_W-1:0] Pc_next,
    output logic              Mem_valid,
    output logic              Mem_wr,
    output logic [ADDR_W-1:0] Mem_addr,
    output logic [DATA_W-1:0] Mem_wdata,
    input  logic              Mem_ready,
    input  logic [DATA_W-1:0] Mem_rdata,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] MDR,
    output logic [ADDR_W-1:0] EPC,
    output logic              Busy,
    output logic              Done,
    output logic              Exc,
    output logic [1:0]        Exc_cause
);

    localparam logic [ADDR_W-1:0] FOUR = ADDR_W'(4);

    state_t            state_q, state_d;
    cause_t            cause_q, cause_d;
    logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d, addr_q, addr_d;
    logic [DATA_W-1:0] ir_q, ir_d, mdr_q, mdr_d, wdata_q, wdata_d;
    logic              we_q, we_d, done_q, done_d, exc_q, exc_d;
    logic              expired;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .clear   (state_q == IDLE),
        .en      (state_q != IDLE),
        .expired (expired)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        ir_d    = ir_q;
        mdr_d   = mdr_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        exc_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (Pc_load) begin
                    pc_d = Pc_next;
                end else if (Fetch_req) begin
                    if (pc_q[1:0] != 2'b00) begin
                        epc_d   = pc_q;
                        pc_d    = EXC_VECTOR;
                        cause_d = MIS_FETCH;
                        exc_d   = 1'b1;
                    end else begin
                        addr_d  = pc_q;
                        we_d    = 1'b0;
                        state_d = FETCH;
                    end
                end else if (Data_req) begin
                    if (Alu_addr[1:0] != 2'b00) begin
                        epc_d   = pc_q - FOUR;
                        pc_d    = EXC_VECTOR;
                        cause_d = MIS_DATA;
                        exc_d   = 1'b1;
                    end else begin
                        addr_d  = Alu_addr;
                        we_d    = Data_we;
                        wdata_d = Store_data;
                        state_d = DATA;
                    end
                end
            end
            FETCH, DATA: begin
                // Ready wins over expiry so the last allowed cycle completes.
                if (Mem_ready) begin
                    if (state_q == FETCH) begin
                        ir_d = Mem_rdata;
                        pc_d = pc_q + FOUR;
                    end else if (!we_q) begin
                        mdr_d = Mem_rdata;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (expired) begin
                    epc_d   = (state_q == FETCH) ? pc_q : pc_q - FOUR;
                    pc_d    = EXC_VECTOR;
                    cause_d = BUS_TIMEOUT;
                    exc_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cause_q <= NONE;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
            ir_q    <= '0;
            mdr_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            cause_q <= cause_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            ir_q    <= ir_d;
            mdr_q   <= mdr_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            exc_q   <= exc_d;
        end
    end

    assign Mem_valid = (state_q != IDLE);
    assign Mem_wr    = (state_q == DATA) && we_q;
    assign Mem_addr  = addr_q;
    assign Mem_wdata = wdata_q;
    assign Busy      = (state_q != IDLE);
    assign Done      = done_q;
    assign Exc       = exc_q;
    assign Exc_cause = cause_q;
    assign PC        = pc_q;
    assign IR        = ir_q;
    assign MDR       = mdr_q;
    assign EPC       = epc_q;

endmodule

// File: tb/tb_mips_mem_port.sv
// Directed bench for mips_mem_port with a transaction-level expectation model.
// Tasks advance expected architectural state; a negedge process compares.
module tb_mips_mem_port;

    localparam int TIMEOUT = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0400;
    localparam logic [31:0] VEC = 32'h0000_0080;

    logic        Clk, Reset_n;
    logic        Fetch_req, Data_req, Data_we, Pc_load;
    logic [31:0] Alu_addr, Store_data, Pc_next;
    logic        Mem_valid, Mem_wr, Mem_ready;
    logic [31:0] Mem_addr, Mem_wdata, Mem_rdata;
    logic [31:0] PC, IR, MDR, EPC;
    logic        Busy, Done, Exc;
    logic [1:0]  Exc_cause;

    mips_mem_port #(
        .DATA_W    (32),
        .ADDR_W    (32),
        .RESET_PC  (RST_PC),
        .EXC_VECTOR(VEC),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Fetch_req (Fetch_req),
        .Data_req  (Data_req),
        .Data_we   (Data_we),
        .Alu_addr  (Alu_addr),
        .Store_data(Store_data),
        .Pc_load   (Pc_load),
        .Pc_next   (Pc_next),
        .Mem_valid (Mem_valid),
        .Mem_wr    (Mem_wr),
        .Mem_addr  (Mem_addr),
        .Mem_wdata (Mem_wdata),
        .Mem_ready (Mem_ready),
        .Mem_rdata (Mem_rdata),
        .PC        (PC),
        .IR        (IR),
        .MDR       (MDR),
        .EPC       (EPC),
        .Busy      (Busy),
        .Done      (Done),
        .Exc       (Exc),
        .Exc_cause (Exc_cause)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_pass = 0;
    bit checking = 1'b0;

    logic [31:0] m_pc, m_ir, m_mdr, m_epc;
    logic [1:0]  m_cause;
    logic        e_busy, e_valid, e_wr, e_done, e_exc;
    logic [31:0] e_addr, e_wdata;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      name, act, exp, $time);
    endtask

    always @(negedge Clk) begin
        if (checking) begin
            chk("pc", PC, m_pc);
            chk("ir", IR, m_ir);
            chk("mdr", MDR, m_mdr);
            chk("epc", EPC, m_epc);
            chk("cause", 32'(Exc_cause), 32'(m_cause));
            chk("busy", 32'(Busy), 32'(e_busy));
            chk("valid", 32'(Mem_valid), 32'(e_valid));
            chk("done", 32'(Done), 32'(e_done));
            chk("exc", 32'(Exc), 32'(e_exc));
            if (e_valid) begin
                chk("wr", 32'(Mem_wr), 32'(e_wr));
                chk("addr", Mem_addr, e_addr);
                if (e_wr) chk("wdata", Mem_wdata, e_wdata);
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = RST_PC; m_ir = '0; m_mdr = '0; m_epc = '0; m_cause = 2'd0;
        e_busy = 0; e_valid = 0; e_wr = 0; e_done = 0; e_exc = 0;
        e_addr = '0; e_wdata = '0;
    endtask

    // lat > TIMEOUT means memory never answers.
    task automatic access(input bit f, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int lat);
        logic [31:0] pc0;
        pc0 = m_pc;
        Fetch_req = f; Data_req = 1'b1; Data_we = we;
        Alu_addr = a; Store_data = wd;
        step();
        Fetch_req = 0; Data_req = 0; Data_we = 0;
        Alu_addr = 32'h0000_0003; Store_data = 32'h0BAD_F00D;
        e_busy = 1; e_valid = 1; e_wr = !f && we;
        e_addr = f ? pc0 : a; e_wdata = wd;
        for (int i = 1; i <= TIMEOUT; i++) begin
            Mem_ready = (i == lat);
            Mem_rdata = (i == lat) ? rd : 32'hFFFF_FFFF;
            step();
            if (i == lat) break;
        end
        Mem_ready = 0; Mem_rdata = 32'hFFFF_FFFF;
        e_busy = 0; e_valid = 0; e_wr = 0;
        if (lat <= TIMEOUT) begin
            e_done = 1;
            if (f) begin
                m_ir = rd;
                m_pc = pc0 + 32'd4;
            end else if (!we) begin
                m_mdr = rd;
            end
        end else begin
            e_exc = 1;
            m_epc = f ? pc0 : pc0 - 32'd4;
            m_pc = VEC;
            m_cause = 2'd3;
        end
        step();
        e_done = 0; e_exc = 0;
    endtask

    task automatic misaligned(input bit f, input logic [31:0] a);
        logic [31:0] pc0;
        pc0 = m_pc;
        Fetch_req = f; Data_req = !f; Data_we = 0; Alu_addr = a;
        step();
        Fetch_req = 0; Data_req = 0;
        e_exc = 1;
        m_epc = f ? pc0 : pc0 - 32'd4;
        m_pc = VEC;
        m_cause = f ? 2'd1 : 2'd2;
        step();
        e_exc = 0;
    endtask

    task automatic pc_load(input logic [31:0] v, input bit also_fetch);
        Pc_load = 1; Pc_next = v; Fetch_req = also_fetch; Data_req = also_fetch;
        Alu_addr = 32'h0000_1000;
        step();
        Pc_load = 0; Fetch_req = 0; Data_req = 0;
        m_pc = v;
        step();
    endtask

    initial begin
        Reset_n = 0; Fetch_req = 0; Data_req = 0; Data_we = 0; Pc_load = 0;
        Alu_addr = '0; Store_data = '0; Pc_next = '0;
        Mem_ready = 0; Mem_rdata = 32'hFFFF_FFFF;
        model_reset();
        step();
        checking = 1'b1;
        chk("rst_pc_lit", PC, 32'h0000_0400);
        chk("rst_maddr_lit", Mem_addr, 32'h0);
        chk("rst_mwdata_lit", Mem_wdata, 32'h0);
        step();
        Reset_n = 1;
        step();

        access(1, 0, 32'h0000_1000, 32'h0, 32'h8C02_0004, 3);
        chk("ir_lit", IR, 32'h8C02_0004);
        chk("pc_lit", PC, 32'h0000_0404);

        access(0, 0, 32'h0000_1000, 32'h0, 32'hDEAD_BEEF, 1);
        chk("mdr_lit", MDR, 32'hDEAD_BEEF);
        chk("pc_after_load_lit", PC, 32'h0000_0404);

        access(0, 1, 32'h0000_1004, 32'h1234_5678, 32'h5555_AAAA, 2);
        chk("mdr_after_store_lit", MDR, 32'hDEAD_BEEF);

        pc_load(32'h0000_2002, 1'b1);
        misaligned(1, 32'h0);
        chk("epc_misf_lit", EPC, 32'h0000_2002);
        chk("pc_vec_lit", PC, 32'h0000_0080);
        chk("cause_misf_lit", 32'(Exc_cause), 32'd1);

        pc_load(32'h0000_0408, 1'b0);
        misaligned(0, 32'h0000_1001);
        chk("epc_misd_lit", EPC, 32'h0000_0404);
        chk("cause_misd_lit", 32'(Exc_cause), 32'd2);

        access(1, 0, 32'h0, 32'h0, 32'h0, TIMEOUT + 1);
        chk("epc_to_lit", EPC, 32'h0000_0080);
        chk("cause_to_lit", 32'(Exc_cause), 32'd3);

        access(1, 0, 32'h0, 32'h0, 32'h2008_0001, TIMEOUT);
        chk("pc_last_cycle_lit", PC, 32'h0000_0084);

        access(0, 1, 32'h0000_2000, 32'hCAFE_0001, 32'h0, TIMEOUT + 1);
        chk("epc_data_to_lit", EPC, 32'h0000_0080);

        pc_load(32'hFFFF_FFFC, 1'b0);
        access(1, 0, 32'h0, 32'h0, 32'h0000_000C, 1);
        chk("pc_wrap_lit", PC, 32'h0000_0000);
        access(0, 0, 32'h0000_0010, 32'h0, 32'h0, TIMEOUT + 1);
        chk("epc_wrap_lit", EPC, 32'hFFFF_FFFC);

        pc_load(32'h0000_0100, 1'b0);
        Fetch_req = 1;
        step();
        Fetch_req = 0;
        e_busy = 1; e_valid = 1; e_wr = 0; e_addr = m_pc;
        step();
        #2;
        Reset_n = 0;
        #1;
        chk("rst_async_valid", 32'(Mem_valid), 32'd0);
        chk("rst_async_ir", IR, 32'h0);
        chk("rst_async_pc", PC, RST_PC);
        model_reset();
        step();
        step();
        Reset_n = 1;
        step();
        step();

        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
